// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; holds the pipeline via stall
// while iterating and returns quotient (LO) and remainder (HI) with a one-cycle valid.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted only in IDLE when annul is low; the caller keeps the
    // instruction in E while stall is high, and valid marks the single cycle in which
    // quot/rem are final. There is no back-pressure on valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [4:0]       cnt;
    logic [WIDTH:0]   rem_p;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] quot_hold;
    logic [WIDTH-1:0] rem_hold;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             lt;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] fin_q;
    logic [WIDTH-1:0] fin_r;

    always_comb begin
        abs_a   = (signed_div && a[WIDTH-1]) ? -a : a;
        abs_b   = (signed_div && b[WIDTH-1]) ? -b : b;
        shifted = {rem_p, dvd[WIDTH-1]};
        lt      = shifted < {2'b00, dvs};
        diff    = shifted[WIDTH:0] - {1'b0, dvs};
        r_next  = lt ? shifted[WIDTH:0] : diff;
        q_next  = {dvd[WIDTH-2:0], ~lt};
        fin_q   = neg_q ? -q_next : q_next;
        fin_r   = neg_r ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rem_p     <= '0;
            dvd       <= '0;
            dvs       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            res_q     <= '0;
            res_r     <= '0;
            quot_hold <= '0;
            rem_hold  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !annul) begin
                        neg_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= signed_div & a[WIDTH-1];
                        cnt   <= '0;
                        rem_p <= '0;
                        if (b == '0) begin
                            // Divide by zero skips iteration; remainder is the raw dividend.
                            res_q <= '1;
                            res_r <= a;
                            state <= S_DONE;
                        end else begin
                            dvd   <= abs_a;
                            dvs   <= abs_b;
                            state <= S_DIV;
                        end
                    end
                end
                S_DIV: begin
                    if (annul) begin
                        state <= S_IDLE;
                    end else begin
                        rem_p <= r_next;
                        dvd   <= q_next;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            res_q <= fin_q;
                            res_r <= fin_r;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Commit results only if the instruction was not flushed.
                    if (!annul) begin
                        quot_hold <= res_q;
                        rem_hold  <= res_r;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        valid     = (state == S_DONE) && !annul;
        quot      = valid ? res_q : quot_hold;
        rem       = valid ? res_r : rem_hold;
        stall     = ((state == S_IDLE) && start && !annul) || (state == S_DIV);
        dbg_state = state;
    end

endmodule
